// File: rtl/updown_counter_param_pkg.sv
// Shared constants and the parameter legality check for the parametrised up/down counter.
package updown_counter_pkg;

  localparam bit CNT_WRAP = 1'b0;
  localparam bit CNT_SAT  = 1'b1;

  // True when the range is non-empty, fits in width bits, and every step value is smaller than the range.
  function automatic bit range_ok(input longint min_v, input longint max_v,
                                  input int width, input int step_w);
    longint lim_v;
    longint step_max;
    lim_v    = (longint'(1) << width) - 1;
    step_max = (longint'(1) << step_w) - 1;
    return (min_v >= 0) && (min_v < max_v) && (max_v <= lim_v) &&
           (step_max < (max_v - min_v + 1));
  endfunction

endpackage

// File: rtl/updown_counter_param_if.sv
// Control and status bundle for updown_counter_param; master drives controls, slave is the counter.
interface updown_counter_param_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              clear;
  logic              load;
  logic [WIDTH-1:0]  d;
  logic              en;
  logic              up_down;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  qd;
  logic              tc_max;
  logic              tc_min;
  logic              lim_pulse;
  logic              ovf_sticky;

  modport master (
    output clear, load, d, en, up_down, step,
    input  qd, tc_max, tc_min, lim_pulse, ovf_sticky
  );

  modport slave (
    input  clear, load, d, en, up_down, step,
    output qd, tc_max, tc_min, lim_pulse, ovf_sticky
  );
endinterface

// File: rtl/updown_counter_param_next.sv
// Combinational next-count for one step, with wrap or saturate at the range limits.
module updown_counter_next
  import updown_counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 4,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 255
) (
  input  logic [WIDTH-1:0]  qd_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              up_down_i,
  input  logic              mode_i,
  output logic [WIDTH-1:0]  nxt_o,
  output logic              evt_o
);
  // Two guard bits keep qd+step and qd-step exact and signed.
  localparam int XW = WIDTH + 2;
  localparam logic signed [XW-1:0] MIN_X   = XW'(MIN_VAL);
  localparam logic signed [XW-1:0] MAX_X   = XW'(MAX_VAL);
  localparam logic signed [XW-1:0] RANGE_X = XW'(MAX_VAL - MIN_VAL + 1);

  logic signed [XW-1:0] qd_x;
  logic signed [XW-1:0] step_x;
  logic signed [XW-1:0] sum_x;
  logic signed [XW-1:0] res_x;

  always_comb begin
    qd_x   = $signed({2'b00, qd_i});
    step_x = $signed(XW'(step_i));
    sum_x  = '0;
    res_x  = qd_x;
    evt_o  = 1'b0;
    if (up_down_i) begin
      sum_x = qd_x + step_x;
      if (sum_x > MAX_X) begin
        evt_o = 1'b1;
        res_x = (mode_i == CNT_SAT) ? MAX_X : sum_x - RANGE_X;
      end else begin
        res_x = sum_x;
      end
    end else begin
      sum_x = qd_x - step_x;
      if (sum_x < MIN_X) begin
        evt_o = 1'b1;
        res_x = (mode_i == CNT_SAT) ? MIN_X : sum_x + RANGE_X;
      end else begin
        res_x = sum_x;
      end
    end
    nxt_o = WIDTH'(res_x);
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: priority mux (reset > clear > load > count), limit flags and event flags.
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 255,
  parameter int STEP_W   = 4,
  parameter int SAT_MODE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  updown_counter_param_if.slave   bus
);
  if (!range_ok(longint'(MIN_VAL), longint'(MAX_VAL), WIDTH, STEP_W)) begin : g_param_check
    $error("updown_counter_param: illegal MIN_VAL/MAX_VAL/WIDTH/STEP_W combination");
  end

  localparam int XW = WIDTH + 2;
  localparam logic [WIDTH-1:0]     MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0]     MAX_W = WIDTH'(MAX_VAL);
  localparam logic signed [XW-1:0] MIN_X = XW'(MIN_VAL);
  localparam logic signed [XW-1:0] MAX_X = XW'(MAX_VAL);
  localparam bit                   MODE  = (SAT_MODE != 0) ? CNT_SAT : CNT_WRAP;

  logic [WIDTH-1:0]     qd_q, qd_d;
  logic                 lim_q, lim_d;
  logic                 ovf_q, ovf_d;
  logic [WIDTH-1:0]     cnt_nxt;
  logic                 cnt_evt;
  logic signed [XW-1:0] d_x;

  updown_counter_next #(
    .WIDTH   (WIDTH),
    .STEP_W  (STEP_W),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .qd_i      (qd_q),
    .step_i    (bus.step),
    .up_down_i (bus.up_down),
    .mode_i    (MODE),
    .nxt_o     (cnt_nxt),
    .evt_o     (cnt_evt)
  );

  always_comb begin
    qd_d  = qd_q;
    lim_d = 1'b0;
    ovf_d = ovf_q;
    d_x   = $signed({2'b00, bus.d});
    if (bus.clear) begin
      qd_d  = MIN_W;
      ovf_d = 1'b0;
    end else if (bus.load) begin
      // An out-of-range load is clamped and reported like a limit event.
      if (d_x < MIN_X) begin
        qd_d  = MIN_W;
        lim_d = 1'b1;
        ovf_d = 1'b1;
      end else if (d_x > MAX_X) begin
        qd_d  = MAX_W;
        lim_d = 1'b1;
        ovf_d = 1'b1;
      end else begin
        qd_d = bus.d;
      end
    end else if (bus.en && (bus.step != '0)) begin
      qd_d = cnt_nxt;
      if (cnt_evt) begin
        lim_d = 1'b1;
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      qd_q  <= MIN_W;
      lim_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      qd_q  <= qd_d;
      lim_q <= lim_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.qd         = qd_q;
  assign bus.tc_max     = (qd_q == MAX_W);
  assign bus.tc_min     = (qd_q == MIN_W);
  assign bus.lim_pulse  = lim_q;
  assign bus.ovf_sticky = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: default range, 10..19 wrap and 10..19 saturate instances.
module tb_updown_counter_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  updown_counter_param_if #(.WIDTH(8), .STEP_W(4)) def_if ();
  updown_counter_param_if #(.WIDTH(8), .STEP_W(3)) wrp_if ();
  updown_counter_param_if #(.WIDTH(8), .STEP_W(3)) sat_if ();

  updown_counter_param u_def (.clk(clk), .reset(reset), .bus(def_if.slave));
  updown_counter_param #(.WIDTH(8), .MIN_VAL(10), .MAX_VAL(19), .STEP_W(3), .SAT_MODE(0))
    u_wrp (.clk(clk), .reset(reset), .bus(wrp_if.slave));
  updown_counter_param #(.WIDTH(8), .MIN_VAL(10), .MAX_VAL(19), .STEP_W(3), .SAT_MODE(1))
    u_sat (.clk(clk), .reset(reset), .bus(sat_if.slave));

  typedef struct {
    int         sel;   // 0 = default, 1 = wrap 10..19, 2 = saturate 10..19
    bit         clr;
    bit         ld;
    logic [7:0] d;
    bit         en;
    bit         up;
    logic [3:0] st;
    logic [7:0] qd;
    bit         tmax;
    bit         tmin;
    bit         lim;
    bit         ovf;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input bit clr, input bit ld, input logic [7:0] d,
                       input bit en, input bit up, input logic [3:0] st);
    def_if.clear = 0; def_if.load = 0; def_if.d = '0; def_if.en = 0; def_if.up_down = 0; def_if.step = '0;
    wrp_if.clear = 0; wrp_if.load = 0; wrp_if.d = '0; wrp_if.en = 0; wrp_if.up_down = 0; wrp_if.step = '0;
    sat_if.clear = 0; sat_if.load = 0; sat_if.d = '0; sat_if.en = 0; sat_if.up_down = 0; sat_if.step = '0;
    case (sel)
      0: begin def_if.clear = clr; def_if.load = ld; def_if.d = d; def_if.en = en;
               def_if.up_down = up; def_if.step = st; end
      1: begin wrp_if.clear = clr; wrp_if.load = ld; wrp_if.d = d; wrp_if.en = en;
               wrp_if.up_down = up; wrp_if.step = st[2:0]; end
      default: begin sat_if.clear = clr; sat_if.load = ld; sat_if.d = d; sat_if.en = en;
               sat_if.up_down = up; sat_if.step = st[2:0]; end
    endcase
  endtask

  task automatic sample(input int sel, output logic [7:0] qd, output logic tmax,
                        output logic tmin, output logic lim, output logic ovf);
    case (sel)
      0: begin qd = def_if.qd; tmax = def_if.tc_max; tmin = def_if.tc_min;
               lim = def_if.lim_pulse; ovf = def_if.ovf_sticky; end
      1: begin qd = wrp_if.qd; tmax = wrp_if.tc_max; tmin = wrp_if.tc_min;
               lim = wrp_if.lim_pulse; ovf = wrp_if.ovf_sticky; end
      default: begin qd = sat_if.qd; tmax = sat_if.tc_max; tmin = sat_if.tc_min;
               lim = sat_if.lim_pulse; ovf = sat_if.ovf_sticky; end
    endcase
  endtask

  // Drive at the falling edge, sample 1 time unit after the next rising edge.
  task automatic step_cycle(input int sel, input bit clr, input bit ld, input logic [7:0] d,
                            input bit en, input bit up, input logic [3:0] st);
    @(negedge clk);
    drive(sel, clr, ld, d, en, up, st);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int sel, input logic [7:0] e_qd,
                           input bit e_tmax, input bit e_tmin, input bit e_lim, input bit e_ovf);
    logic [7:0] a_qd;
    logic a_tmax, a_tmin, a_lim, a_ovf;
    sample(sel, a_qd, a_tmax, a_tmin, a_lim, a_ovf);
    chk({tag, " qd"},         32'(a_qd),   32'(e_qd));
    chk({tag, " tc_max"},     32'(a_tmax), 32'(e_tmax));
    chk({tag, " tc_min"},     32'(a_tmin), 32'(e_tmin));
    chk({tag, " lim_pulse"},  32'(a_lim),  32'(e_lim));
    chk({tag, " ovf_sticky"}, 32'(a_ovf),  32'(e_ovf));
  endtask

  initial begin
    //          sel clr ld d       en up st     qd      max min lim ovf
    vecs[0]  = '{0, 0, 1, 8'd250, 0, 1, 4'd0,  8'd250, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 8'd0,   1, 1, 4'd5,  8'd255, 1, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 8'd0,   1, 1, 4'd1,  8'd0,   0, 1, 1, 1};
    vecs[3]  = '{0, 0, 0, 8'd0,   0, 1, 4'd3,  8'd0,   0, 1, 0, 1};
    vecs[4]  = '{0, 0, 0, 8'd0,   1, 0, 4'd2,  8'd254, 0, 0, 1, 1};
    vecs[5]  = '{0, 0, 1, 8'd5,   1, 1, 4'd2,  8'd5,   0, 0, 0, 1};
    vecs[6]  = '{0, 1, 1, 8'd9,   0, 0, 4'd0,  8'd0,   0, 1, 0, 0};
    vecs[7]  = '{0, 0, 0, 8'd0,   1, 1, 4'd15, 8'd15,  0, 0, 0, 0};
    vecs[8]  = '{0, 0, 0, 8'd0,   1, 0, 4'd0,  8'd15,  0, 0, 0, 0};
    vecs[9]  = '{1, 0, 1, 8'd18,  0, 0, 4'd0,  8'd18,  0, 0, 0, 0};
    vecs[10] = '{1, 0, 0, 8'd0,   1, 1, 4'd3,  8'd11,  0, 0, 1, 1};
    vecs[11] = '{1, 0, 0, 8'd0,   1, 1, 4'd3,  8'd14,  0, 0, 0, 1};
    vecs[12] = '{1, 0, 0, 8'd0,   1, 0, 4'd4,  8'd10,  0, 1, 0, 1};
    vecs[13] = '{1, 0, 0, 8'd0,   1, 0, 4'd1,  8'd19,  1, 0, 1, 1};
    vecs[14] = '{1, 1, 0, 8'd0,   0, 0, 4'd0,  8'd10,  0, 1, 0, 0};
    vecs[15] = '{1, 0, 1, 8'd200, 0, 0, 4'd0,  8'd19,  1, 0, 1, 1};
    vecs[16] = '{1, 1, 0, 8'd0,   0, 0, 4'd0,  8'd10,  0, 1, 0, 0};
    vecs[17] = '{2, 0, 1, 8'd12,  0, 0, 4'd0,  8'd12,  0, 0, 0, 0};
    vecs[18] = '{2, 0, 0, 8'd0,   1, 0, 4'd5,  8'd10,  0, 1, 1, 1};
    vecs[19] = '{2, 0, 0, 8'd0,   1, 0, 4'd5,  8'd10,  0, 1, 1, 1};
    vecs[20] = '{2, 0, 0, 8'd0,   1, 0, 4'd0,  8'd10,  0, 1, 0, 1};
    vecs[21] = '{2, 0, 0, 8'd0,   1, 1, 4'd7,  8'd17,  0, 0, 0, 1};
    vecs[22] = '{2, 0, 0, 8'd0,   1, 1, 4'd2,  8'd19,  1, 0, 0, 1};
    vecs[23] = '{2, 0, 0, 8'd0,   1, 1, 4'd1,  8'd19,  1, 0, 1, 1};
    vecs[24] = '{2, 1, 0, 8'd0,   0, 0, 4'd0,  8'd10,  0, 1, 0, 0};
    vecs[25] = '{2, 0, 1, 8'd19,  0, 0, 4'd0,  8'd19,  1, 0, 0, 0};
    vecs[26] = '{2, 0, 1, 8'd10,  1, 1, 4'd3,  8'd10,  0, 1, 0, 0};

    reset = 1'b1;
    drive(0, 0, 0, 8'd0, 0, 0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset def", 0, 8'd0,  0, 1, 0, 0);
    check_all("reset wrp", 1, 8'd10, 0, 1, 0, 0);
    check_all("reset sat", 2, 8'd10, 0, 1, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Count up to 37, then reset wins over a simultaneous load.
    for (int i = 0; i < 37; i++) step_cycle(0, 0, 0, 8'd0, 1, 1, 4'd1);
    check_all("count37", 0, 8'd37, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 1, 8'd200, 1, 1, 4'd1);
    @(posedge clk);
    #1;
    check_all("reset midcount", 0, 8'd0, 0, 1, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step_cycle(vecs[i].sel, vecs[i].clr, vecs[i].ld, vecs[i].d,
                 vecs[i].en, vecs[i].up, vecs[i].st);
      check_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].qd,
                vecs[i].tmax, vecs[i].tmin, vecs[i].lim, vecs[i].ovf);
      $display("vec %0d sel=%0d clr=%0d ld=%0d d=%0d en=%0d up=%0d step=%0d exp_qd=%0d",
               i, vecs[i].sel, vecs[i].clr, vecs[i].ld, vecs[i].d,
               vecs[i].en, vecs[i].up, vecs[i].st, vecs[i].qd);
    end

    // Clamped low load, then hold with en=0 and a nonzero step.
    step_cycle(1, 1, 0, 8'd0, 0, 0, 4'd0);
    step_cycle(1, 0, 1, 8'd3, 0, 0, 4'd0);
    check_all("clamp load", 1, 8'd10, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step_cycle(1, 0, 0, 8'd0, 0, 1, 4'd7);
      check_all($sformatf("en0 hold%0d", i), 1, 8'd10, 0, 1, 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
